// File: rtl/uart_load_ctrl.sv
// uart_load_ctrl: boot/program-load sequencer.
// Takes memory port B from the CPU while a program image arrives over UART.
// Received bytes are packed into little-endian 32-bit words, and each word is
// written with a one-cycle strobe at an incrementing byte address. The CPU is
// held in reset for the whole load.
//
// States: RUN -> WAIT_FIRST -> RECV -> DONE -> RUN.
// Port B ownership: the loader owns port B (UartOver=0) only in WAIT_FIRST
// and RECV. DONE returns port B to the CPU one cycle before CpuHold drops.
//
// Optional feature, macro LOAD_CHECKSUM_EN:
//   defined   - Checksum is the XOR of every word written in the current load.
//   undefined - Checksum is tied to zero and no accumulator register exists.
//
// RxValid/RxByte handshake: RxValid is a one-cycle strobe with no ready
// signal. A byte is consumed on every rising clk edge where RxValid=1 and the
// FSM is in WAIT_FIRST or RECV. In RUN and DONE the byte is dropped.
module uart_load_ctrl #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned WORD_COUNT_MAX = 16384,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        LoadStart,
    input  logic        RxValid,
    input  logic [7:0]  RxByte,
    output logic [31:0] UartData,
    output logic [31:0] UartAddress,
    output logic        UartWrite,
    output logic        UartOver,
    output logic        CpuHold,
    output logic [15:0] WordCount,
    output logic        LoadError,
    output logic [31:0] Checksum
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [15:0]   MAX_W   = 16'(WORD_COUNT_MAX);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_WAIT_FIRST = 2'd1,
        S_RECV       = 2'd2,
        S_DONE       = 2'd3
    } state_t;

    state_t        state_q;
    logic [31:0]   data_q;
    logic [31:0]   addr_q;
    logic          write_q;
    logic          over_q;
    logic          hold_q;
    logic [15:0]   count_q;
    logic          error_q;
    logic [23:0]   asm_q;      // bytes 0..2 of the word being assembled
    logic [1:0]    idx_q;      // next byte lane within the word
    logic [TW-1:0] timer_q;    // RECV cycles since the last accepted byte

    logic [31:0]   word_d;
    logic [31:0]   addr_d;
    logic [15:0]   count_d;
    logic          max_hit_d;
    logic          start_d;
    logic          word_done_d;

    // Next-word values and the events shared by the FSM and the checksum.
    always_comb begin
        word_d      = {RxByte, asm_q};
        addr_d      = BASE_ADDR + {14'd0, count_q, 2'b00};
        count_d     = (count_q == MAX_W) ? count_q : count_q + 16'd1;
        // The write cycle that brings WordCount to the limit ends the load;
        // anything arriving during it is ignored.
        max_hit_d   = write_q && (count_q == MAX_W);
        start_d     = (state_q == S_RUN) && LoadStart;
        word_done_d = (state_q == S_RECV) && !max_hit_d && RxValid && (idx_q == 2'd3);
    end

    // Load sequencer: state, byte assembly, word writes and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_RUN;
            data_q  <= 32'h0;
            addr_q  <= BASE_ADDR;
            write_q <= 1'b0;
            over_q  <= 1'b1;
            hold_q  <= 1'b0;
            count_q <= 16'h0;
            error_q <= 1'b0;
            asm_q   <= 24'h0;
            idx_q   <= 2'd0;
            timer_q <= '0;
        end else begin
            write_q <= 1'b0;
            case (state_q)
                S_RUN: begin
                    over_q <= 1'b1;
                    hold_q <= 1'b0;
                    if (start_d) begin
                        state_q <= S_WAIT_FIRST;
                        over_q  <= 1'b0;
                        hold_q  <= 1'b1;
                        count_q <= 16'h0;
                        error_q <= 1'b0;
                        idx_q   <= 2'd0;
                        timer_q <= '0;
                    end
                end
                S_WAIT_FIRST: begin
                    // No timeout here: the host may take as long as it likes.
                    if (RxValid) begin
                        asm_q[7:0] <= RxByte;
                        idx_q      <= 2'd1;
                        timer_q    <= '0;
                        state_q    <= S_RECV;
                    end
                end
                S_RECV: begin
                    if (max_hit_d) begin
                        state_q <= S_DONE;
                        over_q  <= 1'b1;
                        idx_q   <= 2'd0;
                    end else if (RxValid) begin
                        timer_q <= '0;
                        idx_q   <= idx_q + 2'd1;
                        case (idx_q)
                            2'd0: asm_q[7:0]   <= RxByte;
                            2'd1: asm_q[15:8]  <= RxByte;
                            2'd2: asm_q[23:16] <= RxByte;
                            default: begin
                                data_q  <= word_d;
                                addr_q  <= addr_d;
                                write_q <= 1'b1;
                                count_q <= count_d;
                            end
                        endcase
                    end else if (timer_q == TO_LAST) begin
                        // Idle long enough: the image is complete. A partial
                        // word is dropped and flagged.
                        state_q <= S_DONE;
                        over_q  <= 1'b1;
                        if (idx_q != 2'd0) begin
                            error_q <= 1'b1;
                        end
                        idx_q <= 2'd0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: begin
                    // DONE: CPU already owns port B; release it from reset now.
                    state_q <= S_RUN;
                    over_q  <= 1'b1;
                    hold_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef LOAD_CHECKSUM_EN
    logic [31:0] csum_q;

    // Running XOR of written words, restarted with each load.
    always_ff @(posedge clk) begin
        if (!reset) begin
            csum_q <= 32'h0;
        end else if (start_d) begin
            csum_q <= 32'h0;
        end else if (word_done_d) begin
            csum_q <= csum_q ^ word_d;
        end
    end

    assign Checksum = csum_q;
`else
    assign Checksum = 32'h0;
`endif

    assign UartData    = data_q;
    assign UartAddress = addr_q;
    assign UartWrite   = write_q;
    assign UartOver    = over_q;
    assign CpuHold     = hold_q;
    assign WordCount   = count_q;
    assign LoadError   = error_q;

endmodule

// File: tb/tb_uart_load_ctrl.sv
// Bench for uart_load_ctrl: directed load sequences with a write scoreboard.
// Two instances share the stimulus: dut (full-size word limit) and dut_max
// (word limit of 2). The short timeout keeps every load brief.
module tb_uart_load_ctrl;

  localparam int unsigned T = 40;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- DUT hookup ----------------
  logic        LoadStart = 1'b0;
  logic        RxValid = 1'b0;
  logic [7:0]  RxByte = 8'h0;

  logic [31:0] UartData, UartAddress, Checksum;
  logic        UartWrite, UartOver, CpuHold, LoadError;
  logic [15:0] WordCount;

  logic [31:0] m_data, m_addr, m_csum;
  logic        m_write, m_over, m_hold, m_err;
  logic [15:0] m_count;

  uart_load_ctrl #(.BASE_ADDR(32'h0), .WORD_COUNT_MAX(16384), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .LoadStart(LoadStart), .RxValid(RxValid), .RxByte(RxByte),
    .UartData(UartData), .UartAddress(UartAddress), .UartWrite(UartWrite),
    .UartOver(UartOver), .CpuHold(CpuHold), .WordCount(WordCount),
    .LoadError(LoadError), .Checksum(Checksum)
  );

  uart_load_ctrl #(.BASE_ADDR(32'h0), .WORD_COUNT_MAX(2), .TIMEOUT_CYCLES(T)) dut_max (
    .clk(clk), .reset(reset), .LoadStart(LoadStart), .RxValid(RxValid), .RxByte(RxByte),
    .UartData(m_data), .UartAddress(m_addr), .UartWrite(m_write),
    .UartOver(m_over), .CpuHold(m_hold), .WordCount(m_count),
    .LoadError(m_err), .Checksum(m_csum)
  );

  // ---------------- checking ----------------
  int unsigned total = 0;
  int unsigned pass_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- scoreboard ----------------
  // Entry layout: {write cycle, address, data}
  logic [95:0] exp_q[$];
  logic [95:0] exp_m_q[$];
  logic        max_en = 1'b0;
  int unsigned m_wr_cnt = 0;

  // Bench model of the load in progress
  int          k = 0;
  logic [31:0] asm_word = 32'h0;
  int unsigned words = 0;
  int unsigned m_words = 0;
  logic [31:0] csum_model = 32'h0;
  int unsigned last_cyc = 0;

  always @(negedge clk) begin
    if (UartWrite) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {32'h0, UartAddress}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [95:0] e;
        e = exp_q.pop_front();
        chk("write_cycle", 64'(cyc_cnt), 64'(e[95:64]));
        chk("write_addr", 64'(UartAddress), 64'(e[63:32]));
        chk("write_data", 64'(UartData), 64'(e[31:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (max_en && m_write) begin
      m_wr_cnt++;
      if (exp_m_q.size() == 0) begin
        chk("max_unexpected_write", {32'h0, m_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [95:0] e;
        e = exp_m_q.pop_front();
        chk("max_write_cycle", 64'(cyc_cnt), 64'(e[95:64]));
        chk("max_write_addr", 64'(m_addr), 64'(e[63:32]));
        chk("max_write_data", 64'(m_data), 64'(e[31:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    LoadStart = 1'b1;
    tick();
    LoadStart = 1'b0;
    k = 0;
    words = 0;
    m_words = 0;
    csum_model = 32'h0;
    chk("start_over", 64'(UartOver), 64'd0);
    chk("start_hold", 64'(CpuHold), 64'd1);
    chk("start_count", 64'(WordCount), 64'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    RxValid = 1'b1;
    RxByte = b;
    asm_word[8*k +: 8] = b;
    k++;
    if (k == 4) begin
      // Byte captured at edge cyc_cnt+1; strobe visible in the cycle after it.
      exp_q.push_back({32'(cyc_cnt + 1), 32'(words * 4), asm_word});
      csum_model = csum_model ^ asm_word;
      words++;
      if (max_en && m_words < 2) begin
        exp_m_q.push_back({32'(cyc_cnt + 1), 32'(m_words * 4), asm_word});
        m_words++;
      end
      k = 0;
    end
    last_cyc = cyc_cnt + 1;
    tick();
    RxValid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_done(input string tag, input int exp_cnt, input logic exp_err);
    int n = 0;
    logic [31:0] exp_csum;
`ifdef LOAD_CHECKSUM_EN
    exp_csum = csum_model;
`else
    exp_csum = 32'h0;
`endif
    while (!UartOver && n < 4 * T) begin
      tick();
      n++;
    end
    chk({tag, "_done_reached"}, 64'(UartOver), 64'd1);
    chk({tag, "_done_timing"}, 64'(cyc_cnt), 64'(last_cyc + T));
    chk({tag, "_done_hold"}, 64'(CpuHold), 64'd1);
    chk({tag, "_count"}, 64'(WordCount), 64'(exp_cnt));
    chk({tag, "_error"}, 64'(LoadError), 64'(exp_err));
    chk({tag, "_checksum"}, 64'(Checksum), 64'(exp_csum));
    tick();
    chk({tag, "_run_hold"}, 64'(CpuHold), 64'd0);
    chk({tag, "_run_over"}, 64'(UartOver), 64'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] rb;

    // Reset for two cycles
    reset = 1'b0;
    tick();
    tick();
    chk("rst_over", 64'(UartOver), 64'd1);
    chk("rst_hold", 64'(CpuHold), 64'd0);
    chk("rst_write", 64'(UartWrite), 64'd0);
    chk("rst_count", 64'(WordCount), 64'd0);
    chk("rst_addr", 64'(UartAddress), 64'd0);
    chk("rst_error", 64'(LoadError), 64'd0);
    chk("rst_checksum", 64'(Checksum), 64'd0);
    reset = 1'b1;
    tick();

    // Bytes ignored in RUN
    send_byte(8'hAA, 1);
    k = 0;
    exp_q.delete();
    words = 0;
    chk("run_ignores_rx", 64'(CpuHold), 64'd0);

    // Two-word load with gaps between bytes
    start_load();
    send_byte(8'h78, 2);
    send_byte(8'h56, 2);
    send_byte(8'h34, 2);
    send_byte(8'h12, 2);
    send_byte(8'hEF, 2);
    send_byte(8'hBE, 2);
    send_byte(8'hAD, 2);
    send_byte(8'hDE, 0);
`ifdef LOAD_CHECKSUM_EN
    chk("fixed_checksum_value", 64'(csum_model), 64'hCC99_E897);
`endif
    wait_done("two_word", 2, 1'b0);

    // Back-to-back bytes: second word overlaps the first write cycle
    start_load();
    for (int i = 0; i < 8; i++) begin
      rb = 8'($urandom_range(0, 255));
      send_byte(rb, 0);
    end
    wait_done("b2b", 2, 1'b0);

    // Partial trailing word
    start_load();
    for (int i = 0; i < 6; i++) begin
      send_byte(8'(i + 1), 1);
    end
    wait_done("partial", 1, 1'b1);

    // Word limit of 2 on dut_max; dut takes all three words
    max_en = 1'b1;
    m_wr_cnt = 0;
    start_load();
    for (int i = 0; i < 12; i++) begin
      rb = 8'($urandom_range(0, 255));
      send_byte(rb, 0);
    end
    chk("max_write_count", 64'(m_wr_cnt), 64'd2);
    chk("max_word_count", 64'(m_count), 64'd2);
    chk("max_over", 64'(m_over), 64'd1);
    chk("max_hold", 64'(m_hold), 64'd0);
    chk("max_error", 64'(m_err), 64'd0);
    wait_done("max_ref", 3, 1'b0);
    max_en = 1'b0;

    // Reset in the middle of a load
    start_load();
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    reset = 1'b0;
    tick();
    chk("midrst_over", 64'(UartOver), 64'd1);
    chk("midrst_hold", 64'(CpuHold), 64'd0);
    chk("midrst_write", 64'(UartWrite), 64'd0);
    reset = 1'b1;
    k = 0;
    repeat (4) tick();
    chk("midrst_count", 64'(WordCount), 64'd0);
    chk("midrst_still_run", 64'(CpuHold), 64'd0);

    repeat (3) tick();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("max_queue_empty", 64'(exp_m_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
